// File: rtl/btn_event_fsm.sv
// Button event classifier: turns a debounced level into short/long/double press pulses.
// Optional auto-repeat while held is enabled by defining BTN_REPEAT_EN.
module btn_event_fsm #(
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300,
  parameter int REPEAT_MS = 200,
  parameter int CNT_W     = 16
) (
  input  logic clk_100Mhz,
  input  logic rst,
  input  logic tick,
  input  logic btn_db,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HELD} state_t;

  localparam logic [CNT_W-1:0] LONG_TH = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] DCLK_TH = CNT_W'(DCLICK_MS - 1);
  localparam longint MAX_MS = (LONG_MS > DCLICK_MS)
                            ? ((LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS)
                            : ((DCLICK_MS > REPEAT_MS) ? DCLICK_MS : REPEAT_MS);

  // Thresholds must be reachable before the counter saturates.
  if (((64'd1 << CNT_W) - 1) < MAX_MS) begin : g_cnt_too_narrow
    $error("btn_event_fsm: CNT_W too small for the configured thresholds");
  end

  state_t           state, nstate;
  logic [CNT_W-1:0] cnt;
  logic             btn_q, rise, fall;
  logic             ev_short, ev_long, ev_double, ev_rep;

  assign rise = btn_db & ~btn_q;
  assign fall = ~btn_db & btn_q;

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TH = CNT_W'(REPEAT_MS - 1);
`endif

  // Edges always take priority over a coincident threshold tick.
  always_comb begin
    nstate    = state;
    ev_short  = 1'b0;
    ev_long   = 1'b0;
    ev_double = 1'b0;
    ev_rep    = 1'b0;
    case (state)
      IDLE:   if (rise) nstate = PRESS1;
      PRESS1: begin
        if (fall) nstate = WAIT2;
        else if (tick && cnt == LONG_TH) begin
          nstate  = HELD;
          ev_long = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) nstate = PRESS2;
        else if (tick && cnt == DCLK_TH) begin
          nstate   = IDLE;
          ev_short = 1'b1;
        end
      end
      PRESS2: begin
        if (fall) begin
          nstate    = IDLE;
          ev_double = 1'b1;
        end
      end
      HELD: begin
        if (fall) nstate = IDLE;
`ifdef BTN_REPEAT_EN
        else if (tick && cnt == REP_TH) ev_rep = 1'b1;
`endif
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      btn_q        <= 1'b1;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      btn_q        <= btn_db;
      state        <= nstate;
      busy         <= (state != IDLE);
      short_press  <= ev_short;
      long_press   <= ev_long;
      double_press <= ev_double;
      if (nstate != state || ev_rep) cnt <= '0;
      else if (tick && state != IDLE && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

`ifdef BTN_REPEAT_EN
  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) repeat_pulse <= 1'b0;
    else     repeat_pulse <= ev_rep;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: doc/btn_event_fsm.md
Name: btn_event_fsm

Overview:
- Classifies debounced button activity into single-cycle events: short press, long press and double press.
- Sits directly downstream of the debounce stage. It consumes btn_db and the shared 1 kHz tick from tickGen.
- Its event pulses drive toggle/mode-control logic in place of a raw edge detector.
- Fully synchronous to clk_100Mhz, apart from the asynchronous reset.

Parameters:
- LONG_MS, 1000: hold duration in ticks that qualifies as a long press.
- DCLICK_MS, 300: gap window in ticks after a release during which a second press makes a double press.
- REPEAT_MS, 200: auto-repeat period in ticks. Used only with BTN_REPEAT_EN.
- CNT_W, 16: tick counter width. Must satisfy 2^CNT_W-1 >= max(LONG_MS, DCLICK_MS, REPEAT_MS).

Ports:
- clk_100Mhz  input   1  system clock, 100 MHz
- rst         input   1  asynchronous, active-high reset
- tick        input   1  one-clk-wide strobe, once per ms
- btn_db      input   1  debounced button level, 1 = pressed
- short_press output  1  one-cycle pulse: press released before LONG_MS, no second press within DCLICK_MS
- long_press  output  1  one-cycle pulse: press held LONG_MS ticks
- double_press output 1  one-cycle pulse: second press released inside the DCLICK_MS window
- repeat_pulse output 1  one-cycle pulse every REPEAT_MS ticks while a long press is held; constant 0 without BTN_REPEAT_EN
- busy        output  1  registered; 1 whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk_100Mhz. rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, cnt = 0.
  - All outputs 0.
  - btn_q (previous btn_db) = 1. A button already held at reset release is therefore ignored until it is released and pressed again.
- Edge detect: rise = btn_db & ~btn_q; fall = ~btn_db & btn_q. btn_q updates every clk.
- cnt:
  - Clears on every state transition.
  - Otherwise increments only on cycles with tick = 1.
  - Saturates at all-ones, never wraps.
- States and transitions:
  - IDLE:
    - rise -> PRESS1.
  - PRESS1:
    - fall -> WAIT2.
    - Else tick & cnt == LONG_MS-1 -> HELD, emit long_press.
    - If fall and the threshold tick occur in the same cycle, fall wins: -> WAIT2, no long_press.
  - WAIT2:
    - rise -> PRESS2.
    - Else tick & cnt == DCLICK_MS-1 -> IDLE, emit short_press.
    - If rise and the timeout tick occur in the same cycle, rise wins: -> PRESS2, no short_press.
  - PRESS2:
    - fall -> IDLE, emit double_press.
    - Hold duration is ignored; no long_press from PRESS2.
  - HELD:
    - fall -> IDLE, no further event.
- Output timing:
  - Event outputs are registered. Each is high for exactly one clk_100Mhz cycle: the cycle after the edge on which the transition is taken.
  - At most one event output is high in any cycle.
- Latency:
  - short_press asserts DCLICK_MS ticks (±1 tick, from tick phase) after release.
  - long_press asserts LONG_MS ticks (±1 tick) after press.
  - double_press asserts 1 clk after the second release.
- busy is registered and follows the state, so it lags the state transition by one clk. busy = 1 in PRESS1, WAIT2, PRESS2 and HELD; 0 in IDLE.
- Reset mid-operation: aborts any sequence immediately with no event emitted. The state returns to IDLE with all outputs 0.
- tick while btn_db is stable in IDLE: no effect; cnt stays 0.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - In HELD, tick & cnt == REPEAT_MS-1 emits repeat_pulse and clears cnt.
  - This repeats for as long as the button is held.
  - The first repeat occurs REPEAT_MS ticks after long_press.
  - A fall in the same cycle as a repeat tick wins: no repeat_pulse.
- Undefined: repeat_pulse is tied to 0 and the HELD counter logic is omitted.

Test Plan:
All scenarios use LONG_MS=10, DCLICK_MS=5, REPEAT_MS=3 and tick every 10 clks.
- Press 4 ticks, release, idle 8 ticks -> one short_press, 5 ticks (±1) after release; no other events; busy returns to 0.
- Press 12 ticks -> long_press once at tick 10 (±1) after press; release -> no further event. With BTN_REPEAT_EN, repeat_pulse at 3 ticks (±1) after long_press, then every 3 ticks, until release.
- Press 2 ticks, release, press again after 2 ticks, release after 2 ticks -> one double_press, 1 clk after the second release; no short_press.
- Hold btn_db = 1 through rst deassertion -> no events while held; release then a 3-tick press gives short_press normally.
- Force rise in the same cycle as the WAIT2 timeout tick -> PRESS2 entered, short_press stays 0. Force fall on the PRESS1 threshold tick -> WAIT2, long_press stays 0.
- Assert rst during PRESS1 after 6 ticks -> outputs 0, busy 0, state IDLE; no event after release.
